// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and helpers for the regfile_mp register file.
//   DEFAULT_DATA_W / DEFAULT_DEPTH : default entry width and entry count
//   RESET_BIT                      : fill value for storage and read data on reset
//   addr_in_range()                : true when an address selects a real entry
package regfile_pkg;

  localparam int unsigned DEFAULT_DATA_W = 8;
  localparam int unsigned DEFAULT_DEPTH  = 4;
  localparam logic        RESET_BIT      = 1'b0;

  // DEPTH need not be a power of two, so an address can exceed the last entry.
  function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: write port, two read ports and error flag of regfile_mp.
//   master : drives wr_en/wr_addr/wr_data, rd_en_a/b, rd_addr_a/b
//   slave  : drives rd_data_a/b, rd_valid_a/b, addr_err
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W,
  parameter int unsigned DEPTH  = DEFAULT_DEPTH
);
  localparam int unsigned ADDR_W = $clog2(DEPTH);

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en_a;
  logic [ADDR_W-1:0] rd_addr_a;
  logic              rd_en_b;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic              rd_valid_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              rd_valid_b;
  logic              addr_err;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
    input  rd_data_a, rd_valid_a, rd_data_b, rd_valid_b, addr_err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
    output rd_data_a, rd_valid_a, rd_data_b, rd_valid_b, addr_err
  );

endinterface

// File: rtl/regfile_read_port.sv
// regfile_read_port: one registered read port of regfile_mp.
//   clk, reset            : clock, synchronous active-high reset
//   rd_en, rd_addr        : read strobe and address
//   mem                   : flattened storage contents
//   wr_fire/addr/data     : committed write this edge (forwarding source)
//   rd_data, rd_valid     : registered read result
//   err_c                 : combinational out-of-range flag for this strobe
// Build option: REGFILE_BYPASS_EN enables write-first forwarding.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W,
  parameter int unsigned DEPTH  = DEFAULT_DEPTH,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rd_en,
  input  logic [ADDR_W-1:0]             rd_addr,
  input  logic [DEPTH-1:0][DATA_W-1:0]  mem,
  input  logic                          wr_fire,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          rd_valid,
  output logic                          err_c
);

  logic              in_range;
  logic [DATA_W-1:0] sel_data;

  // Address check and read mux; out-of-range reads return zero.
  always_comb begin
    in_range = addr_in_range(32'(rd_addr), DEPTH);
    sel_data = '0;
    if (in_range) begin
      sel_data = mem[rd_addr];
    end
`ifdef REGFILE_BYPASS_EN
    // Write-first: a same-edge write to this address wins over storage.
    if (in_range && wr_fire && (wr_addr == rd_addr)) begin
      sel_data = wr_data;
    end
`endif
    err_c = rd_en && !in_range;
  end

`ifndef REGFILE_BYPASS_EN
  // Read-first build ignores the write port.
  logic unused_wr;
  assign unused_wr = ^{wr_fire, wr_addr, wr_data};
`endif

  // Output register; data holds while not strobed.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data  <= {DATA_W{RESET_BIT}};
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= sel_data;
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: flop-based register file, one write port, two registered read ports.
//   clk   : clock, all state updates on rising edge
//   reset : synchronous active-high reset, clears storage and outputs
//   bus   : regfile_mp_if.slave (write port, read ports A/B, addr_err)
// Build option: REGFILE_BYPASS_EN selects write-first reads on address collision;
// storage behaviour is the same in both builds.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W,
  parameter int unsigned DEPTH  = DEFAULT_DEPTH
) (
  input logic           clk,
  input logic           reset,
  regfile_mp_if.slave   bus
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);

  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic                         wr_fire;
  logic                         wr_err_c;
  logic                         err_a_c;
  logic                         err_b_c;

  // Write qualification; out-of-range writes are dropped and flagged.
  always_comb begin
    wr_fire  = bus.wr_en && addr_in_range(32'(bus.wr_addr), DEPTH);
    wr_err_c = bus.wr_en && !addr_in_range(32'(bus.wr_addr), DEPTH);
  end

  // Storage array.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem <= {(DEPTH*DATA_W){RESET_BIT}};
    end else if (wr_fire) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Error pulse: any port strobed an out-of-range address last cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.addr_err <= 1'b0;
    end else begin
      bus.addr_err <= wr_err_c || err_a_c || err_b_c;
    end
  end

  regfile_read_port #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_port_a (
    .clk      (clk),
    .reset    (reset),
    .rd_en    (bus.rd_en_a),
    .rd_addr  (bus.rd_addr_a),
    .mem      (mem),
    .wr_fire  (wr_fire),
    .wr_addr  (bus.wr_addr),
    .wr_data  (bus.wr_data),
    .rd_data  (bus.rd_data_a),
    .rd_valid (bus.rd_valid_a),
    .err_c    (err_a_c)
  );

  regfile_read_port #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_port_b (
    .clk      (clk),
    .reset    (reset),
    .rd_en    (bus.rd_en_b),
    .rd_addr  (bus.rd_addr_b),
    .mem      (mem),
    .wr_fire  (wr_fire),
    .wr_addr  (bus.wr_addr),
    .wr_data  (bus.wr_data),
    .rd_data  (bus.rd_data_b),
    .rd_valid (bus.rd_valid_b),
    .err_c    (err_b_c)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for regfile_mp with DEPTH=5 (exercises
// out-of-range addresses). Expected outputs are pushed when a cycle is driven
// and popped after the following rising edge.
module tb_regfile_mp;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 5;
  localparam int unsigned ADDR_W = $clog2(DEPTH);

  typedef struct {
    logic [DATA_W-1:0] data_a;
    logic              valid_a;
    logic [DATA_W-1:0] data_b;
    logic              valid_b;
    logic              err;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  exp_t              sb[$];
  logic [DATA_W-1:0] model [DEPTH];
  logic [DATA_W-1:0] last_a;
  logic [DATA_W-1:0] last_b;

  regfile_mp_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  regfile_mp #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached got=running exp=finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected read result from the reference model.
  function automatic logic [DATA_W-1:0] model_read(input int ra, input logic we, input int wa,
                                                   input logic [DATA_W-1:0] wd);
    logic [DATA_W-1:0] d;
    d = '0;
    if (ra < int'(DEPTH)) d = model[ra];
`ifdef REGFILE_BYPASS_EN
    if (we && wa < int'(DEPTH) && wa == ra) d = wd;
`endif
    return d;
  endfunction

  // Drive one cycle, push expectation, then pop and compare after the edge.
  task automatic step(input logic rst, input logic we, input int wa, input logic [DATA_W-1:0] wd,
                      input logic rea, input int raa, input logic reb, input int rab,
                      input string tag);
    exp_t e;
    exp_t o;
    reset         = rst;
    bus.wr_en     = we;
    bus.wr_addr   = ADDR_W'(wa);
    bus.wr_data   = wd;
    bus.rd_en_a   = rea;
    bus.rd_addr_a = ADDR_W'(raa);
    bus.rd_en_b   = reb;
    bus.rd_addr_b = ADDR_W'(rab);
    if (rst) begin
      e = '{data_a: '0, valid_a: 1'b0, data_b: '0, valid_b: 1'b0, err: 1'b0};
      for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
      last_a = '0;
      last_b = '0;
    end else begin
      if (rea) last_a = model_read(raa, we, wa, wd);
      if (reb) last_b = model_read(rab, we, wa, wd);
      e.data_a  = last_a;
      e.valid_a = rea;
      e.data_b  = last_b;
      e.valid_b = reb;
      e.err     = (we && wa >= int'(DEPTH)) || (rea && raa >= int'(DEPTH)) ||
                  (reb && rab >= int'(DEPTH));
      if (we && wa < int'(DEPTH)) model[wa] = wd;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    o = sb.pop_front();
    chk({tag, ".data_a"},  32'(bus.rd_data_a),  32'(o.data_a));
    chk({tag, ".valid_a"}, 32'(bus.rd_valid_a), 32'(o.valid_a));
    chk({tag, ".data_b"},  32'(bus.rd_data_b),  32'(o.data_b));
    chk({tag, ".valid_b"}, 32'(bus.rd_valid_b), 32'(o.valid_b));
    chk({tag, ".addr_err"}, 32'(bus.addr_err),  32'(o.err));
  endtask

  task automatic idle(input string tag);
    step(1'b0, 1'b0, 0, 8'h00, 1'b0, 0, 1'b0, 0, tag);
  endtask

  initial begin
    logic [DATA_W-1:0] load [4];
    load[0] = 8'h02; load[1] = 8'h05; load[2] = 8'h00; load[3] = 8'h03;
    last_a = '0;
    last_b = '0;

    // Reset; outputs cleared.
    step(1'b1, 1'b0, 0, 8'h00, 1'b0, 0, 1'b0, 0, "reset0");
    step(1'b1, 1'b0, 0, 8'h00, 1'b0, 0, 1'b0, 0, "reset1");

    // Fresh contents read as zero on both ports.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 0, 8'h00, 1'b1, i, 1'b1, i, "rd_zero");

    // Write then read next cycle.
    step(1'b0, 1'b1, 1, 8'h05, 1'b0, 0, 1'b0, 0, "wr1");
    step(1'b0, 1'b0, 0, 8'h00, 1'b1, 1, 1'b0, 0, "rd1");
    idle("idle_hold");

    // Same-edge write/read collision, then plain re-read.
    step(1'b0, 1'b1, 2, 8'hA5, 1'b0, 0, 1'b1, 2, "collide");
    step(1'b0, 1'b0, 0, 8'h00, 1'b0, 0, 1'b1, 2, "reread");

    // Out-of-range write and read; error is a single-cycle pulse.
    step(1'b0, 1'b1, 6, 8'h77, 1'b1, 7, 1'b0, 0, "oor");
    idle("oor_clear");
    step(1'b0, 1'b0, 0, 8'h00, 1'b0, 0, 1'b1, 5, "oor_b");
    for (int i = 0; i < int'(DEPTH); i++) step(1'b0, 1'b0, 0, 8'h00, 1'b1, i, 1'b0, 0, "scan");

    // Load pattern, then counter-streaming back-to-back reads.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, i, load[i], 1'b0, 0, 1'b0, 0, "load");
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 0, 8'h00, 1'b1, i, 1'b1, 3 - i, "stream");

    // Random traffic including collisions and out-of-range addresses.
    for (int n = 0; n < 40; n++) begin
      step(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), 8'($urandom),
           1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), "rand");
    end

    // Reset overrides a concurrent write and reads.
    step(1'b1, 1'b1, 0, 8'hFF, 1'b1, 0, 1'b1, 1, "rst_wr");
    step(1'b0, 1'b0, 0, 8'h00, 1'b1, 0, 1'b1, 3, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
